// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
//   Shared definitions for the pipeline hazard/forwarding controller:
//   - fwd_sel_e      : EX operand MUX select encoding
//   - DEF_REG_ADDR_W : default register address width
//   - DEF_CNT_W      : default performance counter width (HAZARD_PERF_EN only)
//   Shadow-entry layout (declared inside hazard_ctrl so it follows REG_ADDR_W):
//     EX  entry {rd, reg_write, mem_read}
//     MEM entry {rd, reg_write}
// -----------------------------------------------------------------------------
package hazard_pkg;

  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_CNT_W      = 16;

  // Operand source for the EX-stage MUX_2 pairs.
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,  // register file read data
    FWD_WB  = 2'b01,  // result currently in WB
    FWD_MEM = 2'b10   // ALU result currently in MEM
  } fwd_sel_e;

endpackage : hazard_pkg

// File: rtl/hazard_fwd_cmp.sv
// -----------------------------------------------------------------------------
// hazard_fwd_cmp
//   Forwarding select for one source operand of the instruction in ID.
//   Compares the source address against the EX and MEM shadow entries; the
//   result is registered by the parent and applies once the consumer is in EX.
//   Ports:
//     src_i            source register address
//     use_i            instruction actually reads this source
//     ex_rd_i          destination of the instruction now in EX
//     ex_reg_write_i   EX instruction writes its destination
//     mem_rd_i         destination of the instruction now in MEM
//     mem_reg_write_i  MEM instruction writes its destination
//     sel_o            FWD_MEM / FWD_WB / FWD_REG
// -----------------------------------------------------------------------------
module hazard_fwd_cmp
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] src_i,
  input  logic                  use_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_reg_write_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic                  mem_reg_write_i,
  output fwd_sel_e              sel_o
);

  // x0 is hard-wired to zero, so a source of x0 never forwards; checking the
  // source once covers both producer comparisons. The EX producer is the
  // younger one and therefore wins over the MEM producer.
  always_comb begin
    // NOTE: default every combinational output first so no path leaves it
    // unassigned -- otherwise synthesis infers a latch.
    sel_o = FWD_REG;
    if (use_i && (src_i != '0)) begin
      if (ex_reg_write_i && (ex_rd_i == src_i)) begin
        sel_o = FWD_MEM;
      end else if (mem_reg_write_i && (mem_rd_i == src_i)) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule : hazard_fwd_cmp

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Hazard/forwarding controller for the 5-stage RISC-V pipeline.
//   - Shadows rd/reg_write/mem_read of the instructions in EX and MEM.
//   - Registers forwarding selects at the ID->EX boundary.
//   - Load-use hazard: 1-cycle stall of IF/ID plus a bubble into EX.
//   - Taken branch in EX: flush of IF/ID and ID/EX; beats load-use.
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     id_valid                   ID holds a real instruction
//     id_rs1/id_rs2              ID source addresses
//     id_use_rs1/id_use_rs2      ID instruction reads rs1/rs2
//     id_rd, id_reg_write        ID destination and write enable
//     id_mem_read                ID instruction is a load
//     ex_branch_taken            branch/jump resolved taken in EX
//     fwd_a_sel/fwd_b_sel        EX operand selects (registered)
//     stall_if/stall_id          hold PC / hold IF/ID (combinational)
//     flush_id/flush_ex          zero IF/ID / bubble ID/EX (combinational)
//   Configuration macro HAZARD_PERF_EN adds:
//     stall_cnt, flush_cnt [CNT_W-1:0]  saturating cycle counters of
//                                       load-use stalls / branch flushes
//   The WB-stage entry needs no shadow here: an instruction in MEM has
//   reached WB by the time the consumer evaluated against it sits in EX,
//   and WB-to-ID dependences go through the write-first register file.
// -----------------------------------------------------------------------------
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
`ifdef HAZARD_PERF_EN
  , parameter int CNT_W = DEF_CNT_W
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  ex_branch_taken,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  flush_id,
  output logic                  flush_ex
`ifdef HAZARD_PERF_EN
  , output logic [CNT_W-1:0]    stall_cnt
  , output logic [CNT_W-1:0]    flush_cnt
`endif
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } ex_entry_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
  } mem_entry_t;

  ex_entry_t  ex_q, ex_d;
  mem_entry_t mem_q;
  fwd_sel_e   fwd_a_d, fwd_b_d;
  logic [1:0] fwd_a_q, fwd_b_q;
  logic       load_use;

  // ---------------------------------------------------------------------------
  // Load-use detection. rst_n gates it so nothing is requested while the
  // pipeline is held in reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    load_use = rst_n && id_valid && ex_q.mem_read && (ex_q.rd != '0) &&
               ((id_use_rs1 && (id_rs1 == ex_q.rd)) ||
                (id_use_rs2 && (id_rs2 == ex_q.rd)));
  end

  // ---------------------------------------------------------------------------
  // Stall/flush controls, same cycle. A taken branch discards the dependent
  // instruction anyway, so it takes priority over load-use.
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_if = 1'b0;
    stall_id = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    if (rst_n && ex_branch_taken) begin
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else if (load_use) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      flush_ex = 1'b1;
    end
  end

  // Next EX shadow entry: the ID instruction, or a bubble when ID is empty
  // or the ID/EX register is being flushed.
  always_comb begin
    ex_d = '0;
    if (id_valid && !flush_ex) begin
      ex_d = '{rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};
    end
  end

  // ---------------------------------------------------------------------------
  // Forwarding comparators, one per source operand.
  // ---------------------------------------------------------------------------
  hazard_fwd_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .src_i           (id_rs1),
    .use_i           (id_valid && id_use_rs1),
    .ex_rd_i         (ex_q.rd),
    .ex_reg_write_i  (ex_q.reg_write),
    .mem_rd_i        (mem_q.rd),
    .mem_reg_write_i (mem_q.reg_write),
    .sel_o           (fwd_a_d)
  );

  hazard_fwd_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .src_i           (id_rs2),
    .use_i           (id_valid && id_use_rs2),
    .ex_rd_i         (ex_q.rd),
    .ex_reg_write_i  (ex_q.reg_write),
    .mem_rd_i        (mem_q.rd),
    .mem_reg_write_i (mem_q.reg_write),
    .sel_o           (fwd_b_d)
  );

  // ---------------------------------------------------------------------------
  // Shadow pipeline and registered selects.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge value of the others (mem_q gets the old ex_q, not ex_d).
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      fwd_a_q <= FWD_REG;
      fwd_b_q <= FWD_REG;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= '{rd: ex_q.rd, reg_write: ex_q.reg_write};
      fwd_a_q <= flush_ex ? FWD_REG : fwd_a_d;
      fwd_b_q <= flush_ex ? FWD_REG : fwd_b_d;
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;

  // ---------------------------------------------------------------------------
  // Optional performance counters (saturating).
  // ---------------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_if && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_id && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  // Counters not built: no extra state or ports.
`endif

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed bench for hazard_ctrl. Inputs change 1 time unit after the
//   rising edge; combinational controls are sampled 1 unit later in the same
//   cycle, registered selects 1 unit after the following edge.
//   Control vector compared as {stall_if, stall_id, flush_id, flush_ex}.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
  logic       ex_branch_taken;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall_if, stall_id, flush_id, flush_ex;
`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .id_rd           (id_rd),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .fwd_a_sel       (fwd_a_sel),
    .fwd_b_sel       (fwd_b_sel),
    .stall_if        (stall_if),
    .stall_id        (stall_id),
    .flush_id        (flush_id),
    .flush_ex        (flush_ex)
`ifdef HAZARD_PERF_EN
    , .stall_cnt     (stall_cnt)
    , .flush_cnt     (flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_ctl(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, stall_if, stall_id, flush_id, flush_ex}, {28'd0, exp});
  endtask

  task automatic check_fwd(input string tag, input logic [1:0] exp_a, input logic [1:0] exp_b);
    check({tag, "_a"}, {30'd0, fwd_a_sel}, {30'd0, exp_a});
    check({tag, "_b"}, {30'd0, fwd_b_sel}, {30'd0, exp_b});
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic br);
    id_valid        = v;
    id_rs1          = rs1;
    id_use_rs1      = u1;
    id_rs2          = rs2;
    id_use_rs2      = u2;
    id_rd           = rd;
    id_reg_write    = rw;
    id_mem_read     = mr;
    ex_branch_taken = br;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drive_random();
    drive(1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom),
          5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset with random inputs ----------------
    rst_n = 1'b0;
    drive_random();
    #3;
    check_ctl("rst_ctl0", 4'b0000);
    check_fwd("rst_fwd0", 2'b00, 2'b00);
    tick();
    drive_random();
    #1;
    check_ctl("rst_ctl1", 4'b0000);
    check_fwd("rst_fwd1", 2'b00, 2'b00);
    nop();
    #1 rst_n = 1'b1;
    tick();
    check_ctl("bub_ctl0", 4'b0000);
    check_fwd("bub_fwd0", 2'b00, 2'b00);
    tick();
    check_ctl("bub_ctl1", 4'b0000);
    check_fwd("bub_fwd1", 2'b00, 2'b00);

    // ---------------- EX->EX and gap forwarding ----------------
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);   // add x5
    #1 check_ctl("A_prod_ctl", 4'b0000);
    tick();
    check_fwd("A_prod", 2'b00, 2'b00);
    drive(1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);   // sub rs1=x5
    #1 check_ctl("A_cons_ctl", 4'b0000);
    tick();
    check_fwd("A_exex", 2'b10, 2'b00);
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);  // add x10
    tick();
    nop();                                                          // gap
    tick();
    drive(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);  // rs1=x10
    tick();
    check_fwd("A_gap", 2'b01, 2'b00);

    // ---------------- double hit: MEM outranks WB ----------------
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd6, 1'b0, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);   // rs1 unused
    tick();
    check_fwd("B_dbl", 2'b00, 2'b10);

    // ---------------- load-use ----------------
    drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);   // lw x7
    tick();
    drive(1'b1, 5'd7, 1'b1, 5'd4, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);  // add rs1=x7
    #1 check_ctl("C_stall", 4'b1101);
    tick();
    check_fwd("C_bub", 2'b00, 2'b00);
    #1 check_ctl("C_rel", 4'b0000);                                 // held ID, 1 cycle only
    tick();
    check_fwd("C_wb", 2'b01, 2'b00);

    // ---------------- branch beats load-use ----------------
    drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0);  // lw x12
    tick();
    drive(1'b1, 5'd3, 1'b1, 5'd12, 1'b1, 5'd13, 1'b1, 1'b0, 1'b1);
    #1 check_ctl("D_br", 4'b0011);
    tick();
    check_fwd("D_flush", 2'b00, 2'b00);

    // ---------------- x0 guard ----------------
    nop();
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);   // lw x0
    tick();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    #1 check_ctl("E_nostall", 4'b0000);
    tick();
    check_fwd("E_x0", 2'b00, 2'b00);

    // ---------------- two more load-use stalls ----------------
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'(13 + k), 1'b1, 1'b1, 1'b0);
      tick();
      drive(1'b1, 5'(13 + k), 1'b1, 5'd0, 1'b0, 5'd20, 1'b1, 1'b0, 1'b0);
      #1 check_ctl("F_stall", 4'b1101);
      tick();
      check_ctl("F_rel", 4'b0000);
      tick();
    end
`ifdef HAZARD_PERF_EN
    check("P_stall_cnt", {16'd0, stall_cnt}, 32'd3);
    check("P_flush_cnt", {16'd0, flush_cnt}, 32'd1);
`endif

    // ---------------- reset mid-operation ----------------
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0);  // add x16
    tick();
    drive(1'b1, 5'd16, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b1, 1'b0); // lw x15, rs1=x16
    tick();
    check_fwd("G_pre", 2'b10, 2'b00);
    drive(1'b1, 5'd15, 1'b1, 5'd0, 1'b0, 5'd17, 1'b1, 1'b0, 1'b0);
    #1 check_ctl("G_stall", 4'b1101);
    rst_n = 1'b0;
    #1;
    check_ctl("G_rst_ctl", 4'b0000);
    check_fwd("G_rst_fwd", 2'b00, 2'b00);
`ifdef HAZARD_PERF_EN
    check("G_rst_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
    #2 rst_n = 1'b1;
    #1 check_ctl("G_after", 4'b0000);
    tick();
    check_fwd("G_after_fwd", 2'b00, 2'b00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_hazard_ctrl
